// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter sharing one slave port.
// Master 0 is the fetch port, master 1 the data port. Ties from IDLE are
// broken round-robin; every grant is separated by at least one IDLE cycle.
// Optional stall watchdog is enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_addr_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_m1;    // 1 when master 1 was the most recently served
    logic   timeout;
    logic   gnt0;
    logic   gnt1;

    // State register and round-robin history; reset aborts any transfer at once.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
        end else begin
            state <= state_next;
            if (state == GNT0) begin
                last_m1 <= 1'b0;
            end else if (state == GNT1) begin
                last_m1 <= 1'b1;
            end
        end
    end

    // Next-state: grant from IDLE only, hold while the owner keeps cyc high.
    // NOTE: the default assignment first guarantees no latch is inferred for
    // paths the case statement does not cover.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_m1 ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) state_next = IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    // Slave-side mux: the granted master drives the bus, everything is 0 in IDLE.
    always_comb begin
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        wbs_sel_o  = 4'h0;
        wbs_addr_o = 32'h0;
        wbs_dat_o  = 32'h0;
        grant_o    = 2'b00;
        case (state)
            GNT0: begin
                wbs_cyc_o  = m0_cyc_i;
                wbs_stb_o  = m0_stb_i;
                wbs_we_o   = m0_we_i;
                wbs_sel_o  = m0_sel_i;
                wbs_addr_o = m0_addr_i;
                wbs_dat_o  = m0_dat_i;
                grant_o    = 2'b01;
            end
            GNT1: begin
                wbs_cyc_o  = m1_cyc_i;
                wbs_stb_o  = m1_stb_i;
                wbs_we_o   = m1_we_i;
                wbs_sel_o  = m1_sel_i;
                wbs_addr_o = m1_addr_i;
                wbs_dat_o  = m1_dat_i;
                grant_o    = 2'b10;
            end
            default: ;
        endcase
    end

    // Responses reach only the granted, strobing master; err wins over ack.
    assign m0_ack_o = wbs_ack_i & gnt0 & m0_stb_i & ~wbs_err_i;
    assign m1_ack_o = wbs_ack_i & gnt1 & m1_stb_i & ~wbs_err_i;
    assign m0_err_o = (wbs_err_i | timeout) & gnt0 & m0_stb_i;
    assign m1_err_o = (wbs_err_i | timeout) & gnt1 & m1_stb_i;

    // Read data is broadcast; ack alone marks it valid.
    assign m0_dat_o = wbs_dat_i;
    assign m1_dat_o = wbs_dat_i;

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [15:0] stall_cnt;

    // Stall watchdog: count strobed cycles without a slave response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= 16'h0;
        end else if (state == IDLE || wbs_ack_i || wbs_err_i || timeout) begin
            stall_cnt <= 16'h0;
        end else if (wbs_stb_o) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign timeout = (state != IDLE) && (stall_cnt == 16'(TIMEOUT_CYCLES));
`else
    // No watchdog: a limit of 0 is outside the legal range, so this is always 0
    // and a stalled slave holds the grant indefinitely.
    assign timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed, table-driven bench for wb_arbiter.
// One table row per clock cycle; inputs are driven on the falling edge and
// outputs sampled 1 ns later, well before the next rising edge.
module tb_wb_arbiter;

    localparam logic [31:0] M0_ADDR = 32'h0000_0100;
    localparam logic [31:0] M1_ADDR = 32'h0000_0200;
    localparam logic [31:0] M0_WDAT = 32'h0000_C0DE;
    localparam logic [31:0] M1_WDAT = 32'h5555_AAAA;
    localparam logic [3:0]  M0_SEL  = 4'hF;
    localparam logic [3:0]  M1_SEL  = 4'h3;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_addr, wbs_wdat, wbs_rdat;
    logic        wbs_ack, wbs_err;
    logic [1:0]  grant;

    int total;
    int passed;

    wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_cyc_i   (m0_cyc),
        .m0_stb_i   (m0_stb),
        .m0_we_i    (1'b0),
        .m0_sel_i   (M0_SEL),
        .m0_addr_i  (M0_ADDR),
        .m0_dat_i   (M0_WDAT),
        .m0_dat_o   (m0_rdat),
        .m0_ack_o   (m0_ack),
        .m0_err_o   (m0_err),
        .m1_cyc_i   (m1_cyc),
        .m1_stb_i   (m1_stb),
        .m1_we_i    (1'b1),
        .m1_sel_i   (M1_SEL),
        .m1_addr_i  (M1_ADDR),
        .m1_dat_i   (M1_WDAT),
        .m1_dat_o   (m1_rdat),
        .m1_ack_o   (m1_ack),
        .m1_err_o   (m1_err),
        .wbs_cyc_o  (wbs_cyc),
        .wbs_stb_o  (wbs_stb),
        .wbs_we_o   (wbs_we),
        .wbs_sel_o  (wbs_sel),
        .wbs_addr_o (wbs_addr),
        .wbs_dat_o  (wbs_wdat),
        .wbs_dat_i  (wbs_rdat),
        .wbs_ack_i  (wbs_ack),
        .wbs_err_i  (wbs_err),
        .grant_o    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus its hand-computed expected outputs.
    // ctl = {wbs_cyc, wbs_stb}; resp = {m0_ack, m0_err, m1_ack, m1_err}.
    typedef struct {
        logic        c0, s0, c1, s1, ack, err;
        logic [31:0] dat;
        logic [1:0]  grant;
        logic [1:0]  ctl;
        logic [3:0]  resp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic ack, input logic err, input logic [31:0] dat);
        m0_cyc   = c0;
        m0_stb   = s0;
        m1_cyc   = c1;
        m1_stb   = s1;
        wbs_ack  = ack;
        wbs_err  = err;
        wbs_rdat = dat;
    endtask

    // Bus-side expectations for a given grant: the owner's fixed attributes.
    task automatic check_bus(input string tag, input logic [1:0] g);
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_wdat;
        e_we = 1'b0; e_sel = 4'h0; e_addr = 32'h0; e_wdat = 32'h0;
        if (g == 2'b01) begin
            e_we = 1'b0; e_sel = M0_SEL; e_addr = M0_ADDR; e_wdat = M0_WDAT;
        end else if (g == 2'b10) begin
            e_we = 1'b1; e_sel = M1_SEL; e_addr = M1_ADDR; e_wdat = M1_WDAT;
        end
        check({tag, "_we"},   32'(wbs_we),  32'(e_we));
        check({tag, "_sel"},  32'(wbs_sel), 32'(e_sel));
        check({tag, "_addr"}, wbs_addr, e_addr);
        check({tag, "_wdat"}, wbs_wdat, e_wdat);
    endtask

    initial begin
        total  = 0;
        passed = 0;

        // Both masters simultaneously after reset: m0 first, one IDLE gap, then m1.
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        2'b00,2'b00,4'b0000});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,32'h1111_1111,2'b01,2'b11,4'b1000});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        2'b01,2'b00,4'b0000});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        2'b00,2'b00,4'b0000});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        2'b10,2'b11,4'b0000});
        // m1 write with ack and err together: err wins.
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h2222_2222,2'b10,2'b11,4'b0001});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b10,2'b00,4'b0000});
        // Four simultaneous-request rounds: m0, m1, m0, m1.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            logic [3:0] r;
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            r = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,               2'b00,2'b00,4'b0000});
            vecs.push_back('{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,32'hA000_0000 + 32'(k),g,    2'b11,r});
            vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,               g,    2'b00,4'b0000});
        end
        // m0 read of 0x100, slave answers on cycle 3; late ack after release is dropped.
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00,2'b00,4'b0000});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b01,2'b11,4'b0000});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b01,2'b11,4'b0000});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'hDEAD_BEEF,2'b01,2'b11,4'b1000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b01,2'b00,4'b0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        2'b00,2'b00,4'b0000});

        // Reset held with every input active: everything must stay quiet.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ctl",   32'({wbs_cyc, wbs_stb}), 32'h0);
        check("rst_resp",  32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
        check_bus("rst", 2'b00);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Table: one row per cycle.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1,
                  vecs[i].ack, vecs[i].err, vecs[i].dat);
            #1;
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("v%0d_ctl", i),   32'({wbs_cyc, wbs_stb}), 32'(vecs[i].ctl));
            check($sformatf("v%0d_resp", i),  32'({m0_ack, m0_err, m1_ack, m1_err}), 32'(vecs[i].resp));
            check($sformatf("v%0d_m0dat", i), m0_rdat, vecs[i].dat);
            check($sformatf("v%0d_m1dat", i), m1_rdat, vecs[i].dat);
            check_bus($sformatf("v%0d", i), vecs[i].grant);
        end

        // Stalled slave: m0 strobes and the slave never responds.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall%0d_grant", i), 32'(grant), 32'h1);
`ifdef WB_ARBITER_TIMEOUT_EN
            check($sformatf("stall%0d_err", i), 32'({m0_err, m0_ack}), (i == 8) ? 32'h2 : 32'h0);
`else
            check($sformatf("stall%0d_err", i), 32'({m0_err, m0_ack}), 32'h0);
`endif
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("stall_release_grant", 32'(grant), 32'h0);

        // Reset asserted between edges in the middle of an m0 transfer.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("pre_abort_grant", 32'(grant), 32'h1);
        wbs_ack = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_ctl",   32'({wbs_cyc, wbs_stb}), 32'h0);
        check("abort_resp",  32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
        check_bus("abort", 2'b00);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check("tie_after_reset_grant", 32'(grant), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
